// File: rtl/if_id_fuse_buffer.sv
// IF/ID pipeline register with a one-deep lookahead slot that fuses LUI+ADDI
// pairs targeting the same register. Fusion is built only when IF_FUSE_EN is defined.
module if_id_fuse_buffer #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      imem_instr,
  input  logic             imem_valid,
  input  logic             stall,
  input  logic             flush,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic             id_valid,
  output logic             id_fused,
  output logic [11:0]      id_fuse_imm,
  output logic             fuse_skip,
  output logic [CNT_W-1:0] fuse_count
);

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  // Valid semantics: there is no ready. A word is accepted whenever
  // imem_valid=1 on a clk edge with stall=0 and flush=0; id_valid marks a
  // word that decode must consume on that edge unless stall is high.
  logic             slot_valid, slot_valid_n;
  logic [31:0]      slot_instr, slot_instr_n;
  logic [31:0]      slot_pc, slot_pc_n;
  logic [31:0]      id_instr_n, id_pc_n;
  logic             id_valid_n, id_fused_n, fuse_skip_n;
  logic [11:0]      id_fuse_imm_n;
  logic [CNT_W-1:0] fuse_count_n;
  logic             fusible;

`ifdef IF_FUSE_EN
  logic [4:0] slot_rd;
  assign slot_rd = slot_instr[11:7];
  assign fusible = slot_valid
                && (slot_instr[6:0] == OP_LUI) && (slot_rd != 5'd0)
                && imem_valid
                && (imem_instr[6:0] == OP_IMM) && (imem_instr[14:12] == 3'b000)
                && (imem_instr[11:7] == slot_rd) && (imem_instr[19:15] == slot_rd);
`else
  assign fusible = 1'b0;
`endif

  always_comb begin
    slot_valid_n  = slot_valid;
    slot_instr_n  = slot_instr;
    slot_pc_n     = slot_pc;
    id_instr_n    = id_instr;
    id_pc_n       = id_pc;
    id_valid_n    = id_valid;
    id_fused_n    = id_fused;
    id_fuse_imm_n = id_fuse_imm;
    fuse_skip_n   = 1'b0;
    fuse_count_n  = fuse_count;
    if (flush) begin
      slot_valid_n  = 1'b0;
      id_valid_n    = 1'b0;
      id_instr_n    = NOP_INSTR;
      id_fused_n    = 1'b0;
      id_fuse_imm_n = 12'd0;
    end else if (stall) begin
      // hold everything; fuse_skip already defaults low
    end else if (fusible) begin
      slot_valid_n  = 1'b0;
      id_valid_n    = 1'b1;
      id_instr_n    = slot_instr;
      id_pc_n       = slot_pc;
      id_fused_n    = 1'b1;
      id_fuse_imm_n = imem_instr[31:20];
      fuse_skip_n   = 1'b1;
      if (fuse_count != {CNT_W{1'b1}}) fuse_count_n = fuse_count + CNT_W'(1);
    end else begin
      if (slot_valid) begin
        id_valid_n = 1'b1;
        id_instr_n = slot_instr;
        id_pc_n    = slot_pc;
      end else begin
        id_valid_n = 1'b0;
        id_instr_n = NOP_INSTR;
      end
      id_fused_n    = 1'b0;
      id_fuse_imm_n = 12'd0;
      slot_valid_n  = imem_valid;
      if (imem_valid) begin
        slot_instr_n = imem_instr;
        slot_pc_n    = pc_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid  <= 1'b0;
      slot_instr  <= 32'd0;
      slot_pc     <= 32'd0;
      id_instr    <= NOP_INSTR;
      id_pc       <= 32'd0;
      id_valid    <= 1'b0;
      id_fused    <= 1'b0;
      id_fuse_imm <= 12'd0;
      fuse_skip   <= 1'b0;
      fuse_count  <= '0;
    end else begin
      slot_valid  <= slot_valid_n;
      slot_instr  <= slot_instr_n;
      slot_pc     <= slot_pc_n;
      id_instr    <= id_instr_n;
      id_pc       <= id_pc_n;
      id_valid    <= id_valid_n;
      id_fused    <= id_fused_n;
      id_fuse_imm <= id_fuse_imm_n;
      fuse_skip   <= fuse_skip_n;
      fuse_count  <= fuse_count_n;
    end
  end

endmodule

// File: tb/tb_if_id_fuse_buffer.sv
// Directed bench for if_id_fuse_buffer; expectations follow IF_FUSE_EN when it
// is defined for the build, otherwise the plain one-slot register behaviour.
module tb_if_id_fuse_buffer;

`ifdef IF_FUSE_EN
  localparam logic FE = 1'b1;
`else
  localparam logic FE = 1'b0;
`endif
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] LUI5  = 32'h123452B7;
  localparam logic [31:0] ADDI5 = 32'h67828293;
  localparam logic [31:0] ADDI6 = 32'h67828313;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, imem_instr;
  logic        imem_valid, stall, flush;
  logic [31:0] id_instr, id_pc;
  logic        id_valid, id_fused, fuse_skip;
  logic [11:0] id_fuse_imm;
  logic [1:0]  fuse_count;

  int vectors = 0;
  int miscompares = 0;

  if_id_fuse_buffer #(.CNT_W(2), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .imem_instr(imem_instr),
    .imem_valid(imem_valid), .stall(stall), .flush(flush),
    .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
    .id_fused(id_fused), .id_fuse_imm(id_fuse_imm), .fuse_skip(fuse_skip),
    .fuse_count(fuse_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] instr,
                            input logic [31:0] pc, input logic fused, input logic [11:0] imm,
                            input logic skip, input logic [1:0] cnt);
    check({tag, ".valid"}, 32'(id_valid), 32'(v));
    check({tag, ".instr"}, id_instr, v ? instr : NOP);
    if (v) check({tag, ".pc"}, id_pc, pc);
    check({tag, ".fused"}, 32'(id_fused), 32'(fused));
    check({tag, ".imm"}, 32'(id_fuse_imm), 32'(imm));
    check({tag, ".skip"}, 32'(fuse_skip), 32'(skip));
    check({tag, ".count"}, 32'(fuse_count), 32'(cnt));
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    imem_valid = v;
    pc_in      = pc;
    imem_instr = instr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    #12;
    expect_out("reset", 1'b0, NOP, 32'd0, 1'b0, 12'd0, 1'b0, 2'd0);
    check("reset.pc", id_pc, 32'd0);
    rst = 1'b1;

    // two plain words: 2-cycle latency, second drains when imem_valid drops
    drive(1'b1, 32'h0, 32'h00500093); tick();
    expect_out("s1.c1", 1'b0, NOP, 32'h0, 1'b0, 12'd0, 1'b0, 2'd0);
    drive(1'b1, 32'h4, 32'h00100113); tick();
    expect_out("s1.c2", 1'b1, 32'h00500093, 32'h0, 1'b0, 12'd0, 1'b0, 2'd0);
    drive(1'b0, 32'h0, 32'h0); tick();
    expect_out("s1.c3", 1'b1, 32'h00100113, 32'h4, 1'b0, 12'd0, 1'b0, 2'd0);
    tick();
    expect_out("s1.c4", 1'b0, NOP, 32'h0, 1'b0, 12'd0, 1'b0, 2'd0);

    // matching LUI+ADDI pair
    drive(1'b1, 32'h10, LUI5); tick();
    expect_out("s2.lui", 1'b0, NOP, 32'h0, 1'b0, 12'd0, 1'b0, 2'd0);
    drive(1'b1, 32'h14, ADDI5); tick();
    expect_out("s2.pair", 1'b1, LUI5, 32'h10, FE, FE ? 12'h678 : 12'h0, FE, FE ? 2'd1 : 2'd0);
    drive(1'b0, 32'h0, 32'h0); tick();
    expect_out("s2.after", !FE, ADDI5, 32'h14, 1'b0, 12'd0, 1'b0, FE ? 2'd1 : 2'd0);
    tick();
    expect_out("s2.idle", 1'b0, NOP, 32'h0, 1'b0, 12'd0, 1'b0, FE ? 2'd1 : 2'd0);

    // ADDI to a different rd never fuses
    drive(1'b1, 32'h10, LUI5); tick();
    drive(1'b1, 32'h14, ADDI6); tick();
    expect_out("s3.lui", 1'b1, LUI5, 32'h10, 1'b0, 12'd0, 1'b0, FE ? 2'd1 : 2'd0);
    drive(1'b0, 32'h0, 32'h0); tick();
    expect_out("s3.addi", 1'b1, ADDI6, 32'h14, 1'b0, 12'd0, 1'b0, FE ? 2'd1 : 2'd0);
    tick();

    // stall with a valid output in flight and the partner ADDI waiting
    drive(1'b1, 32'h20, 32'h00500093); tick();
    drive(1'b1, 32'h24, LUI5); tick();
    expect_out("s4.pre", 1'b1, 32'h00500093, 32'h20, 1'b0, 12'd0, 1'b0, FE ? 2'd1 : 2'd0);
    drive(1'b1, 32'h28, ADDI5); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("s4.stall", 1'b1, 32'h00500093, 32'h20, 1'b0, 12'd0, 1'b0, FE ? 2'd1 : 2'd0);
    end
    stall = 1'b0; tick();
    expect_out("s4.pair", 1'b1, LUI5, 32'h24, FE, FE ? 12'h678 : 12'h0, FE, FE ? 2'd2 : 2'd0);
    drive(1'b0, 32'h0, 32'h0); tick();
    expect_out("s4.after", !FE, ADDI5, 32'h28, 1'b0, 12'd0, 1'b0, FE ? 2'd2 : 2'd0);
    tick();

    // flush coincident with the partner ADDI
    drive(1'b1, 32'h30, LUI5); tick();
    drive(1'b1, 32'h34, ADDI5); flush = 1'b1; tick();
    expect_out("s5.flush", 1'b0, NOP, 32'h0, 1'b0, 12'd0, 1'b0, FE ? 2'd2 : 2'd0);
    flush = 1'b0; drive(1'b0, 32'h0, 32'h0); tick();
    expect_out("s5.empty", 1'b0, NOP, 32'h0, 1'b0, 12'd0, 1'b0, FE ? 2'd2 : 2'd0);

    // three more pairs: 2-bit counter saturates at 3
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40 + 32'(8 * i), LUI5); tick();
      expect_out("s6.lui", !FE && (i > 0), ADDI5, 32'h44 + 32'(8 * i) - 32'd8, 1'b0, 12'd0, 1'b0,
                 FE ? ((i == 0) ? 2'd2 : 2'd3) : 2'd0);
      drive(1'b1, 32'h44 + 32'(8 * i), ADDI5); tick();
      expect_out("s6.pair", 1'b1, LUI5, 32'h40 + 32'(8 * i), FE, FE ? 12'h678 : 12'h0, FE,
                 FE ? 2'd3 : 2'd0);
      if (i == 0) begin
        drive(1'b0, 32'h0, 32'h0); stall = 1'b1; tick();
        expect_out("s6.stall", 1'b1, LUI5, 32'h40, FE, FE ? 12'h678 : 12'h0, 1'b0,
                   FE ? 2'd3 : 2'd0);
        stall = 1'b0;
      end
    end
    drive(1'b0, 32'h0, 32'h0); tick();
    expect_out("s6.drain", !FE, ADDI5, 32'h54, 1'b0, 12'd0, 1'b0, FE ? 2'd3 : 2'd0);

    // asynchronous reset mid-operation with a LUI in the slot
    drive(1'b1, 32'h80, LUI5); tick();
    drive(1'b0, 32'h0, 32'h0);
    #2 rst = 1'b0;
    #1 expect_out("s7.rst", 1'b0, NOP, 32'h0, 1'b0, 12'd0, 1'b0, 2'd0);
    check("s7.rst.pc", id_pc, 32'd0);
    #1 rst = 1'b1;
    tick();
    expect_out("s7.empty", 1'b0, NOP, 32'h0, 1'b0, 12'd0, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_fuse_buffer.md
Name: if_id_fuse_buffer

Overview:
- Sits between the PC/instruction-memory fetch and the decode stage of the RV32I pipeline; it is the IF/ID pipeline register.
- Holds each fetched instruction in a one-deep lookahead slot so it can detect LUI+ADDI macro-op pairs writing the same register.
- A detected pair is issued to decode as one fused op, and the block pulses fuse_skip.
- Honours pipeline stall (load waiting on dmem) and flush (branch/jal/jalr redirect).

Parameters:
- CNT_W, 16, width of the saturating fused-pair performance counter.
- NOP_INSTR, 32'h00000013, instruction presented on id_instr when the output is invalid (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- pc_in  in  32  address of the instruction on imem_instr
- imem_instr  in  32  fetched instruction word
- imem_valid  in  1  imem_instr/pc_in valid this cycle
- stall  in  1  freeze all state (load && !dmem_valid)
- flush  in  1  redirect; discard slot and output
- id_instr  out  32  instruction to decode (first of pair when fused)
- id_pc  out  32  PC of id_instr
- id_valid  out  1  id_instr valid
- id_fused  out  1  id_instr is LUI fused with a following ADDI
- id_fuse_imm  out  12  ADDI imm[11:0] of the fused pair; 0 when not fused
- fuse_skip  out  1  one-cycle pulse: the second instruction of a pair was absorbed
- fuse_count  out  CNT_W  number of fused pairs issued, saturating

Behaviour:
- Reset (rst=0, async): slot empty, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_fused=0, id_fuse_imm=0, fuse_skip=0, fuse_count=0.
- All outputs are registered. Normal latency from imem_valid to id_valid is 2 cycles: one cycle into the slot, one to the output.
- Priority each clk edge: flush > stall > normal.
- Flush:
  - Slot emptied, id_valid=0, id_instr=NOP_INSTR, id_fused=0, id_fuse_imm=0, fuse_skip=0.
  - The incoming imem word that cycle is discarded.
  - fuse_count is unchanged.
- Stall (no flush): every register holds its value, except fuse_skip, which is forced to 0.
- Fusible pair condition, all of the following:
  - slot valid;
  - slot opcode 7'b0110111 (LUI) with slot rd != 0;
  - incoming imem_valid=1, opcode 7'b0010011, funct3 3'b000;
  - incoming rd == slot rd, and incoming rs1 == slot rd.
- Normal cycle, by case:
  - Fusible pair: id_instr=slot instr, id_pc=slot pc, id_valid=1, id_fused=1, id_fuse_imm=imem_instr[31:20], fuse_skip=1, slot emptied, fuse_count+1, saturating at all-ones.
  - Slot valid, imem_valid=1, not fusible: slot issued (id_valid=1, id_fused=0, id_fuse_imm=0), and the slot loads {pc_in, imem_instr}.
  - Slot valid, imem_valid=0: slot drained to output, slot emptied. No waiting for a partner.
  - Slot empty, imem_valid=1: id_valid=0, id_instr=NOP_INSTR, slot loads the new word.
  - Slot empty, imem_valid=0: id_valid=0, id_instr=NOP_INSTR.
- fuse_skip is high only in the cycle the fused op is presented; it is 0 otherwise.
- Back-to-back LUIs: the first is issued unfused and the second is held as a fusion candidate.
- A fused pair's ADDI never appears separately on id_instr.
- Reset asserted mid-operation clears everything immediately. No partial pair survives.

Optional Feature:
- Macro IF_FUSE_EN.
- Defined: fusion detection and fuse_count active as described above.
- Undefined:
  - The fusible-pair case never matches.
  - id_fused, id_fuse_imm, fuse_skip and fuse_count are tied to 0.
  - The buffer still behaves as a one-slot, 2-cycle-latency IF/ID register.

Test Plan:
- Reset, then imem_valid pulses pc=0x0 0x00500093, pc=0x4 0x00100113 -> id_valid=1 for pc 0x0 in cycle 2 and pc 0x4 in cycle 3 (the second word drains once imem_valid drops), id_fused=0, fuse_count=0.
- pc=0x10 0x123452B7 (lui x5,0x12345), then pc=0x14 0x67828293 (addi x5,x5,0x678) -> one output with id_instr=0x123452B7, id_pc=0x10, id_fused=1, id_fuse_imm=0x678, fuse_skip=1 for exactly one cycle, fuse_count=1; 0x67828293 never issued.
- Same LUI, then ADDI with rd=x6 (0x67828313) -> both issued separately, id_fused=0, fuse_skip=0.
- LUI loaded, then stall=1 for 3 cycles while the ADDI is on imem -> outputs frozen and fuse_skip=0 during the stall; after release with the ADDI still valid, the fused op issues once.
- LUI in slot, flush=1 coincident with the ADDI -> id_valid=0, id_instr=0x00000013, slot empty next cycle, fuse_count unchanged.
- CNT_W=2, five fusible pairs -> fuse_count saturates at 3; with IF_FUSE_EN undefined, the pair from scenario 2 issues as two instructions and fuse_count stays 0.
